// File: rtl/bit_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg: shared definitions for the bit_serializer block.
//   - state_t   : serializer FSM state encoding (S_DONE has its own code)
//   - DEF_WIDTH : default word length
//   - DEF_DIV   : default clock cycles per serial bit
//   - cnt_w()   : counter width helper, never narrower than 1 bit
// ---------------------------------------------------------------------------
package ser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // Bits needed to hold the values 0 .. n-1, with a 1-bit minimum so a
    // counter for n=1 still has a legal vector width.
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_div.sv
// ---------------------------------------------------------------------------
// bit_tick_div: loadable down-counter that times one serial bit.
// Loading sets the count to DIV-1; the counter then decrements to zero and
// parks there. tick is high whenever the count is zero, i.e. in the last
// cycle of the current bit.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (count -> 0)
//   load  in   restart the bit period (count -> DIV-1)
//   tick  out  terminal count: current bit ends this cycle
// ---------------------------------------------------------------------------
module bit_tick_div
    import ser_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int             DW     = cnt_w(DIV);
    localparam logic [DW-1:0]  RELOAD = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (load) begin
            div_cnt <= RELOAD;
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
        end
    end

    assign tick = (div_cnt == '0);

endmodule

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer: parallel-to-serial stage feeding a serial pattern detector.
// A WIDTH-bit word is accepted on a load_valid/load_ready handshake and sent
// MSB first on ser_out, each bit held for DIV clocks. After the last bit a
// one-cycle S_DONE state pulses done, then the block returns to S_IDLE.
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready is high only in S_IDLE and never
// while rst is asserted; load_valid at any other time is ignored and
// load_data is only sampled on the transfer edge.
//
// Optional feature (macro SER_LOOP_EN): adds input loop. When loop is high
// as the last bit ends, the captured word is replayed from a shadow copy
// with no gap and no done pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   loop        in   (SER_LOOP_EN only) replay the word continuously
//   load_valid  in   load_data is valid
//   load_ready  out  block can accept a word
//   load_data   in   WIDTH-bit word to serialize
//   ser_out     out  serial stream, MSB first; IDLE_LVL when not shifting
//   bit_stb     out  pulse in the first cycle of every bit
//   busy        out  high in every S_SHIFT cycle
//   done        out  pulse in the cycle after the last bit
// ---------------------------------------------------------------------------
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   DIV      = DEF_DIV,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SER_LOOP_EN
    input  logic             loop,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             ser_out_nxt, bit_stb_nxt, busy_nxt, done_nxt;
    logic             div_load, div_tick;
    logic             handshake;

`ifdef SER_LOOP_EN
    logic [WIDTH-1:0] shadow_reg;
`endif

    assign load_ready = (state == S_IDLE) & ~rst;
    assign handshake  = load_valid & load_ready;

    bit_tick_div #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .tick (div_tick)
    );

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        ser_out_nxt = ser_out;
        bit_stb_nxt = 1'b0;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        div_load    = 1'b0;

        case (state)
            S_IDLE: begin
                ser_out_nxt = IDLE_LVL;
                busy_nxt    = 1'b0;
                if (handshake) begin
                    state_nxt   = S_SHIFT;
                    shift_nxt   = load_data;
                    bit_cnt_nxt = LAST_IDX;
                    ser_out_nxt = load_data[WIDTH-1];
                    bit_stb_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                    div_load    = 1'b1;
                end
            end

            S_SHIFT: begin
                busy_nxt = 1'b1;
                if (div_tick) begin
                    if (bit_cnt != '0) begin
                        // Rotate rather than zero-fill: only the top bit is
                        // ever driven out, and the bits wrapping around to
                        // the bottom are never reached before the word ends.
                        shift_nxt   = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
                        bit_cnt_nxt = bit_cnt - BW'(1);
                        ser_out_nxt = shift_reg[WIDTH-2];
                        bit_stb_nxt = 1'b1;
                        div_load    = 1'b1;
                    end else begin
`ifdef SER_LOOP_EN
                        if (loop) begin
                            shift_nxt   = shadow_reg;
                            bit_cnt_nxt = LAST_IDX;
                            ser_out_nxt = shadow_reg[WIDTH-1];
                            bit_stb_nxt = 1'b1;
                            div_load    = 1'b1;
                        end else begin
                            state_nxt   = S_DONE;
                            ser_out_nxt = IDLE_LVL;
                            busy_nxt    = 1'b0;
                            done_nxt    = 1'b1;
                        end
`else
                        state_nxt   = S_DONE;
                        ser_out_nxt = IDLE_LVL;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
`endif
                    end
                end
            end

            S_DONE: begin
                state_nxt   = S_IDLE;
                ser_out_nxt = IDLE_LVL;
                busy_nxt    = 1'b0;
            end

            default: begin
                state_nxt   = S_IDLE;
                ser_out_nxt = IDLE_LVL;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ser_out   <= IDLE_LVL;
            bit_stb   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ser_out   <= ser_out_nxt;
            bit_stb   <= bit_stb_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef SER_LOOP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (handshake) begin
            shadow_reg <= load_data;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer: directed bench for bit_serializer.
// u1 is WIDTH=8, DIV=1; u3 is WIDTH=8, DIV=3. Both use IDLE_LVL=0.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// so each falling edge observes the cycle following the previous rising edge.
// With SER_LOOP_EN defined the loop port is connected and the loop scenario
// is included.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    logic       clk;
    logic       rst;

    logic       lv1, rdy1, ser1, stb1, busy1, done1;
    logic [7:0] d1;
    logic       lv3, rdy3, ser3, stb3, busy3, done3;
    logic [7:0] d3;
`ifdef SER_LOOP_EN
    logic       loop1;
    logic       loop3;
`endif

    int n_checks;
    int n_fail;

    bit_serializer #(.WIDTH(8), .DIV(1), .IDLE_LVL(1'b0)) u1 (
        .clk        (clk),
        .rst        (rst),
`ifdef SER_LOOP_EN
        .loop       (loop1),
`endif
        .load_valid (lv1),
        .load_ready (rdy1),
        .load_data  (d1),
        .ser_out    (ser1),
        .bit_stb    (stb1),
        .busy       (busy1),
        .done       (done1)
    );

    bit_serializer #(.WIDTH(8), .DIV(3), .IDLE_LVL(1'b0)) u3 (
        .clk        (clk),
        .rst        (rst),
`ifdef SER_LOOP_EN
        .loop       (loop3),
`endif
        .load_valid (lv3),
        .load_ready (rdy3),
        .load_data  (d3),
        .ser_out    (ser3),
        .bit_stb    (stb3),
        .busy       (busy3),
        .done       (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input int cyc, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s@%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Call with a handshake pending on the next rising edge (edge T).
    // Checks cycles T+1..T+8 (bits), T+9 (done) and T+10 (ready again).
    // At T+1 load_valid/load_data are set to hold_valid/next_data.
    task automatic check_word(input logic [7:0] w, input logic hold_valid,
                              input logic [7:0] next_data, input string tag);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk1({tag, "_ser"},   k, ser1,  w[8-k]);
            chk1({tag, "_stb"},   k, stb1,  1'b1);
            chk1({tag, "_busy"},  k, busy1, 1'b1);
            chk1({tag, "_done"},  k, done1, 1'b0);
            chk1({tag, "_ready"}, k, rdy1,  1'b0);
            if (k == 1) begin
                lv1 = hold_valid;
                d1  = next_data;
            end
        end
        @(negedge clk);
        chk1({tag, "_done"},  9, done1, 1'b1);
        chk1({tag, "_ser"},   9, ser1,  1'b0);
        chk1({tag, "_busy"},  9, busy1, 1'b0);
        chk1({tag, "_stb"},   9, stb1,  1'b0);
        chk1({tag, "_ready"}, 9, rdy1,  1'b0);
        @(negedge clk);
        chk1({tag, "_ready"}, 10, rdy1,  1'b1);
        chk1({tag, "_done"},  10, done1, 1'b0);
        chk1({tag, "_busy"},  10, busy1, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        lv1 = 1'b1;
        d1  = 8'h55;
        lv3 = 1'b0;
        d3  = 8'h00;
`ifdef SER_LOOP_EN
        loop1 = 1'b0;
        loop3 = 1'b0;
`endif

        // Reset held two cycles with load_valid high: nothing is captured.
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk1("rst_ready", k, rdy1,  1'b0);
            chk1("rst_ser",   k, ser1,  1'b0);
            chk1("rst_busy",  k, busy1, 1'b0);
            chk1("rst_done",  k, done1, 1'b0);
            chk1("rst_stb",   k, stb1,  1'b0);
        end
        rst = 1'b0;
        lv1 = 1'b0;
        @(negedge clk);
        chk1("post_rst_ready", 0, rdy1,  1'b1);
        chk1("post_rst_busy",  0, busy1, 1'b0);
        chk1("post_rst_ser",   0, ser1,  1'b0);
        chk1("post_rst_ready3", 0, rdy3, 1'b1);

        // Single word A5; data changed right after the handshake.
        lv1 = 1'b1;
        d1  = 8'hA5;
        check_word(8'hA5, 1'b0, 8'h00, "a5");

        // Back-to-back: FF then 0F with load_valid held high throughout.
        lv1 = 1'b1;
        d1  = 8'hFF;
        check_word(8'hFF, 1'b1, 8'h0F, "ff");
        check_word(8'h0F, 1'b0, 8'h00, "0f");

        // Mid-word reset: C3 loaded, rst high in cycle T+4.
        lv1 = 1'b1;
        d1  = 8'hC3;
        w   = 8'hC3;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk1("mid_ser",  k, ser1,  w[8-k]);
            chk1("mid_busy", k, busy1, 1'b1);
            if (k == 1) lv1 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_ser",   5, ser1,  1'b0);
        chk1("mid_rst_busy",  5, busy1, 1'b0);
        chk1("mid_rst_done",  5, done1, 1'b0);
        chk1("mid_rst_stb",   5, stb1,  1'b0);
        chk1("mid_rst_ready", 5, rdy1,  1'b0);
        rst = 1'b0;
        for (int k = 6; k <= 14; k++) begin
            @(negedge clk);
            chk1("mid_no_done", k, done1, 1'b0);
            chk1("mid_idle_ser", k, ser1, 1'b0);
            chk1("mid_ready",   k, rdy1,  1'b1);
        end
        lv1 = 1'b1;
        d1  = 8'h3C;
        check_word(8'h3C, 1'b0, 8'hFF, "3c");

        // DIV=3: word 80, each bit held three cycles.
        lv3 = 1'b1;
        d3  = 8'h80;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk1("div3_ser",  k, ser3,  (k <= 3) ? 1'b1 : 1'b0);
            chk1("div3_stb",  k, stb3,  ((k - 1) % 3 == 0) ? 1'b1 : 1'b0);
            chk1("div3_busy", k, busy3, 1'b1);
            chk1("div3_done", k, done3, 1'b0);
            if (k == 1) begin
                lv3 = 1'b0;
                d3  = 8'hFF;
            end
        end
        @(negedge clk);
        chk1("div3_done",  25, done3, 1'b1);
        chk1("div3_busy",  25, busy3, 1'b0);
        chk1("div3_ready", 25, rdy3,  1'b0);
        @(negedge clk);
        chk1("div3_ready", 26, rdy3,  1'b1);
        chk1("div3_done",  26, done3, 1'b0);

`ifdef SER_LOOP_EN
        // Loop C3 continuously; drop loop during the third pass.
        loop1 = 1'b1;
        lv1   = 1'b1;
        d1    = 8'hC3;
        w     = 8'hC3;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk1("loop_ser",   k, ser1,  w[7 - ((k - 1) % 8)]);
            chk1("loop_stb",   k, stb1,  1'b1);
            chk1("loop_busy",  k, busy1, 1'b1);
            chk1("loop_done",  k, done1, 1'b0);
            chk1("loop_ready", k, rdy1,  1'b0);
            if (k == 1) begin
                lv1 = 1'b0;
                d1  = 8'h00;
            end
            if (k == 20) loop1 = 1'b0;
        end
        @(negedge clk);
        chk1("loop_end_done", 25, done1, 1'b1);
        chk1("loop_end_ser",  25, ser1,  1'b0);
        @(negedge clk);
        chk1("loop_end_ready", 26, rdy1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
